// File: rtl/cnn_pkg.sv
// Shared CNN definitions: frame sequencer FSM encoding and layer-1 geometry.
package cnn_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam int L1_IMG_W     = 28;
    localparam int L1_IMG_H     = 28;
    localparam int L1_OUT_BEATS = 169;

endpackage

// File: rtl/layer1_frame_ctrl_if.sv
// Frame RAM read port plus the pixel stream and beat return to the layer-1 conv/pool block.
// Handshake: mem_data is valid one cycle after mem_rd; pix_valid/lay_valid are single-cycle
// qualifiers with no backpressure, so every cycle they are high carries exactly one beat.
interface layer1_frame_ctrl_if #(
    parameter int ADDR_W = 10
);
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_data;
    logic              layer_rst_n;
    logic [7:0]        pix_out;
    logic              pix_valid;
    logic              lay_valid;

    modport master (
        output mem_rd, mem_addr, layer_rst_n, pix_out, pix_valid,
        input  mem_data, lay_valid
    );

    modport slave (
        input  mem_rd, mem_addr, layer_rst_n, pix_out, pix_valid,
        output mem_data, lay_valid
    );
endinterface

// File: rtl/frame_addr_gen.sv
// Raster-order frame RAM address counter with enable, synchronous clear and last-address flag.
module frame_addr_gen #(
    parameter int ADDR_W = 10,
    parameter int N_PIX  = 784
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_PIX - 1);

    assign last = (addr == LAST_ADDR);

    // Wrapping after the last read leaves the counter at 0 for the next frame.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            addr <= '0;
        end else if (en) begin
            addr <= last ? '0 : addr + 1'b1;
        end
    end

endmodule

// File: rtl/layer1_frame_ctrl.sv
// Layer-1 frame sequencer: clears the layer, streams one image from frame RAM, counts pooled beats.
// Optional drain watchdog enabled by defining FRAME_TIMEOUT_EN.
module layer1_frame_ctrl
    import cnn_pkg::*;
#(
    parameter int IMG_W     = L1_IMG_W,
    parameter int IMG_H     = L1_IMG_H,
    parameter int ADDR_W    = 10,
    parameter int OUT_BEATS = L1_OUT_BEATS,
    parameter int CLR_CYC   = 2
`ifdef FRAME_TIMEOUT_EN
    ,
    parameter int TMO_CYC   = 255
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 hold,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [7:0]           out_cnt,
    output state_t               state_dbg,
    layer1_frame_ctrl_if.master  fif
);

    localparam logic [7:0] OUT_BEATS_B = 8'(OUT_BEATS);
    localparam logic [7:0] CLR_LOAD    = 8'(CLR_CYC - 1);

    state_t            state;
    state_t            state_nxt;
    logic              start_acc;
    logic              rd_en;
    logic              mem_rd_i;
    logic              last_addr;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        clr_cnt;
    logic [7:0]        out_cnt_nxt;
    logic              pix_valid_q;
    logic [7:0]        pix_q;
    logic              tmo_hit;

    assign start_acc = (state == ST_IDLE) && start;
    assign rd_en     = (state == ST_STREAM) && !hold;

    frame_addr_gen #(
        .ADDR_W (ADDR_W),
        .N_PIX  (IMG_W * IMG_H)
    ) u_addr_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (start_acc),
        .en   (rd_en),
        .addr (addr),
        .last (last_addr)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; completion looks at the count including this cycle's beat
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start) state_nxt = ST_CLEAR;
            ST_CLEAR:  if (clr_cnt == 8'd0) state_nxt = ST_STREAM;
            ST_STREAM: if (rd_en && last_addr) state_nxt = ST_DRAIN;
            ST_DRAIN:  if ((out_cnt_nxt == OUT_BEATS_B) || tmo_hit) state_nxt = ST_DONE;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Outputs; the comb strobes are forced inactive while rst is high
    always_comb begin
        busy     = !rst && ((state == ST_CLEAR) || (state == ST_STREAM) || (state == ST_DRAIN));
        done     = !rst && (state == ST_DONE);
        mem_rd_i = !rst && rd_en;
    end

    assign fif.mem_rd      = mem_rd_i;
    assign fif.mem_addr    = addr;
    assign fif.layer_rst_n = !(rst || (state == ST_CLEAR));
    assign state_dbg       = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            clr_cnt <= 8'd0;
        end else if (start_acc) begin
            clr_cnt <= CLR_LOAD;
        end else if ((state == ST_CLEAR) && (clr_cnt != 8'd0)) begin
            clr_cnt <= clr_cnt - 8'd1;
        end
    end

    always_comb begin
        out_cnt_nxt = out_cnt;
        if (start_acc) begin
            out_cnt_nxt = 8'd0;
        end else if (fif.lay_valid && ((state == ST_STREAM) || (state == ST_DRAIN))
                     && (out_cnt != 8'hff)) begin
            out_cnt_nxt = out_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_cnt <= 8'd0;
        end else begin
            out_cnt <= out_cnt_nxt;
        end
    end

    // RAM data lands in the pix_valid cycle, so it is forwarded then and held afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_valid_q <= 1'b0;
            pix_q       <= 8'd0;
        end else begin
            pix_valid_q <= mem_rd_i;
            if (pix_valid_q) pix_q <= fif.mem_data;
        end
    end

    assign fif.pix_valid = pix_valid_q;
    assign fif.pix_out   = pix_valid_q ? fif.mem_data : pix_q;

`ifdef FRAME_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TMO_CYC - 1);

    logic [7:0] tmo_cnt;
    logic       err_q;

    assign tmo_hit = (state == ST_DRAIN) && !fif.lay_valid && (tmo_cnt == TMO_LAST)
                     && (out_cnt_nxt != OUT_BEATS_B);

    // Counts consecutive beat-less DRAIN cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            if ((state != ST_DRAIN) || fif.lay_valid) tmo_cnt <= 8'd0;
            else                                      tmo_cnt <= tmo_cnt + 8'd1;
            if (start_acc)    err_q <= 1'b0;
            else if (tmo_hit) err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign tmo_hit = 1'b0;
    assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_layer1_frame_ctrl.sv
// Directed bench for layer1_frame_ctrl: RAM model, layer beat model, pixel scoreboard.
// The watchdog frame is exercised only when FRAME_TIMEOUT_EN is defined.
module tb_layer1_frame_ctrl;
  import cnn_pkg::*;

  localparam int ADDR_W = 10;
  localparam int N_PIX  = 784;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       start = 1'b0;
  logic       hold  = 1'b0;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] out_cnt;
  state_t     state_dbg;

  layer1_frame_ctrl_if #(.ADDR_W(ADDR_W)) fif ();

  layer1_frame_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .hold      (hold),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .out_cnt   (out_cnt),
    .state_dbg (state_dbg),
    .fif       (fif.master)
  );

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // frame RAM model: RAM[a] = a[7:0]
  always @(posedge clk) begin
    if (fif.mem_rd) fif.mem_data <= fif.mem_addr[7:0];
  end

  // scoreboard / monitor
  logic [7:0] exp_q[$];
  logic [7:0] exp_pix;
  int reads       = 0;
  int pix_seen    = 0;
  int clr_run     = 0;
  int clr_len     = 0;
  int done_cnt    = 0;
  int done_cyc    = 0;
  int last_rd_cyc = 0;

  always @(negedge clk) begin
    if (!fif.layer_rst_n && !rst) begin
      if (clr_run == 0) begin
        exp_q.delete();
        for (int i = 0; i < N_PIX; i++) exp_q.push_back(8'(i));
        reads    = 0;
        pix_seen = 0;
      end
      clr_run++;
    end else if (clr_run > 0) begin
      clr_len = clr_run;
      clr_run = 0;
    end
    if (fif.mem_rd) begin
      chk("rd_addr", 32'(fif.mem_addr), 32'(reads));
      if (fif.mem_addr == ADDR_W'(N_PIX - 1)) last_rd_cyc = cyc;
      reads++;
    end
    if (fif.pix_valid) begin
      chk("pix_q_nonempty", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        exp_pix = exp_q.pop_front();
        chk("pix_out", fif.pix_out, exp_pix);
      end
      pix_seen++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  // layer model: one pooled beat per 4 pixels, then an optional spaced tail after the last pixel
  int stream_beats = 160;
  int tail_beats   = 9;
  int tail_gap     = 3;
  int lay_sent     = 0;
  int gap_cnt      = 0;
  int lay_cyc      = 0;

  always begin
    @(posedge clk);
    #1;
    fif.lay_valid = 1'b0;
    if (!fif.layer_rst_n) begin
      lay_sent = 0;
      gap_cnt  = 0;
    end else if (lay_sent < stream_beats) begin
      if (pix_seen >= 4 * (lay_sent + 1)) begin
        fif.lay_valid = 1'b1;
        lay_sent++;
        lay_cyc = cyc;
      end
    end else if ((lay_sent < stream_beats + tail_beats) && (pix_seen == N_PIX)) begin
      if (gap_cnt == 0) begin
        fif.lay_valid = 1'b1;
        lay_sent++;
        lay_cyc = cyc;
        gap_cnt = tail_gap - 1;
      end else begin
        gap_cnt--;
      end
    end
  end

  // driver tasks
  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_addr(input int a, input string tag);
    int i;
    i = 0;
    while (!(fif.mem_addr == ADDR_W'(a) && state_dbg == ST_STREAM) && i < 2000) begin
      tick();
      i++;
    end
    chk(tag, 32'(fif.mem_addr), 32'(a));
  endtask

  task automatic wait_state(input state_t s, input string tag);
    int i;
    i = 0;
    while (state_dbg != s && i < 2000) begin
      tick();
      i++;
    end
    chk(tag, 32'(state_dbg), 32'(s));
  endtask

  // mode 0: done one cycle after last layer beat; 1: two cycles after last read; 2: watchdog
  task automatic finish_frame(input string tag, input int d0, input int mode,
                              input logic [7:0] exp_cnt, input logic exp_err);
    int i;
    int exp_done;
    i = 0;
    while (done_cnt == d0 && i < 3000) begin
      tick();
      i++;
    end
    chk({tag, "_done_seen"}, 32'(done_cnt - d0), 1);
    if (mode == 0)      exp_done = lay_cyc + 1;
    else if (mode == 1) exp_done = last_rd_cyc + 2;
    else                exp_done = last_rd_cyc + 256;
    chk({tag, "_done_cyc"}, 32'(done_cyc), 32'(exp_done));
    repeat (3) tick();
    chk({tag, "_done_once"}, 32'(done_cnt - d0), 1);
    chk({tag, "_reads"}, 32'(reads), 32'(N_PIX));
    chk({tag, "_pix_left"}, 32'(exp_q.size()), 0);
    chk({tag, "_clr_len"}, 32'(clr_len), 2);
    chk({tag, "_out_cnt"}, out_cnt, exp_cnt);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_state"}, 32'(state_dbg), 32'(ST_IDLE));
    chk({tag, "_err"}, err, exp_err);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int d0;
    int p0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_layer_rst_n", fif.layer_rst_n, 0);
    chk("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_mem_rd", fif.mem_rd, 0);
    chk("rst_pix_valid", fif.pix_valid, 0);
    chk("rst_mem_addr", 32'(fif.mem_addr), 0);
    chk("rst_pix_out", fif.pix_out, 0);
    chk("rst_out_cnt", out_cnt, 0);
    chk("post_rst_layer_rst_n", fif.layer_rst_n, 1);
    while (cyc < 5) tick();

    // frame 1: beats finish in DRAIN, start pulsed during DRAIN
    stream_beats = 160; tail_beats = 9; tail_gap = 3;
    d0 = done_cnt;
    pulse_start();
    chk("f1_busy_after_start", busy, 1);
    wait_state(ST_DRAIN, "f1_drain");
    pulse_start();
    finish_frame("f1", d0, 0, 8'd169, 1'b0);

    // frame 2: all beats in STREAM, hold at 300, start pulsed during STREAM
    stream_beats = 169; tail_beats = 0;
    d0 = done_cnt;
    pulse_start();
    wait_addr(300, "f2_addr300");
    hold = 1'b1;
    p0 = pix_seen;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("f2_hold_no_rd", fif.mem_rd, 0);
      tick();
    end
    chk("f2_hold_inflight", 32'(pix_seen - p0), 1);
    chk("f2_hold_resume_addr", 32'(fif.mem_addr), 300);
    hold = 1'b0;
    wait_addr(500, "f2_addr500");
    pulse_start();
    finish_frame("f2", d0, 1, 8'd169, 1'b0);

    // frame 3: rst mid-frame at address 400
    d0 = done_cnt;
    pulse_start();
    wait_addr(400, "f3_addr400");
    rst = 1'b1;
    @(negedge clk);
    chk("f3_rst_layer_rst_n", fif.layer_rst_n, 0);
    chk("f3_rst_mem_rd", fif.mem_rd, 0);
    chk("f3_rst_busy", busy, 0);
    tick();
    chk("f3_state", 32'(state_dbg), 32'(ST_IDLE));
    chk("f3_mem_addr", 32'(fif.mem_addr), 0);
    chk("f3_pix_valid", fif.pix_valid, 0);
    chk("f3_pix_out", fif.pix_out, 0);
    chk("f3_out_cnt", out_cnt, 0);
    chk("f3_done", done, 0);
    rst = 1'b0;
    repeat (4) tick();
    chk("f3_no_done", 32'(done_cnt - d0), 0);
    chk("f3_idle", 32'(state_dbg), 32'(ST_IDLE));

    // frame 4: fresh frame after the abort
    stream_beats = 160; tail_beats = 9; tail_gap = 3;
    d0 = done_cnt;
    pulse_start();
    finish_frame("f4", d0, 0, 8'd169, 1'b0);

`ifdef FRAME_TIMEOUT_EN
    // frame 5: layer stops after 100 beats, watchdog ends the frame
    stream_beats = 100; tail_beats = 0;
    d0 = done_cnt;
    pulse_start();
    finish_frame("f5", d0, 2, 8'd100, 1'b1);
    stream_beats = 169;
    d0 = done_cnt;
    pulse_start();
    chk("f6_err_cleared", err, 0);
    finish_frame("f6", d0, 1, 8'd169, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
